alu_ctrl_md: RTL and testbench
==============================

Name: alu_ctrl_md

Overview:
- Next-generation ALU controller for the RV32 core, adding the RV32M extension.
- Decodes ALUOp/Funct7/Funct3 into a 5-bit Operation code and registers it into the ID→EX boundary.
- Sequences multi-cycle MUL/DIV ops with a counter FSM that stalls the front end until the op's latency elapses.
- Sits between the main decoder (ALUOp source) and the ALU / mul-div datapath in EX.

Parameters:
- ENABLE_M, 1, when 0 Funct7=0000001 decodes as illegal.
- MUL_LAT, 3, EX-stage cycles for MUL/MULH/MULHSU/MULHU (≥1).
- DIV_LAT, 33, EX-stage cycles for DIV/DIVU/REM/REMU (≥1).
- CNT_W, $clog2(DIV_LAT+1), latency counter width (derived).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ID-stage instruction valid
- ALUOp  input  3  class from main decoder (000 R, 001 load/store, 010 I-ALU, 011 jump, 100 branch, 101 AUIPC, 110 LUI)
- Funct7  input  7  instr[31:25]
- Funct3  input  3  instr[14:12]
- flush  input  1  kill EX contents (branch/jump redirect)
- in_ready  output  1  ID may advance (= !stall)
- ex_valid  output  1  EX register holds a live op
- Operation  output  5  registered ALU operation code
- ex_illegal  output  1  registered illegal-encoding flag
- md_start  output  1  one-cycle pulse, first EX cycle of an M op
- md_busy  output  1  FSM in BUSY
- md_done  output  1  final EX cycle of an M op
- stall  output  1  hold ID and EX registers

Behaviour:
- Reset is synchronous, active-high; clk is the single clock. On reset: ex_valid=0, Operation=5'b00000, ex_illegal=0, state=IDLE, counter=0. Combinational outputs then give stall=0, in_ready=1, md_* = 0.
- Decode is combinational. Base codes {1'b0, 4-bit} are unchanged from the current generation:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111.
  - SLT 1010, SLTU 1100, LUI 1110.
  - Branches: BEQ 1000, BNE 1001, BLT 1010, BGE 1011, BLTU 1100, BGEU 1101.
  - ALUOp 001/011/101 → ADD.
- M ops: ALUOp=000 and Funct7=0000001 → {2'b10, Funct3}.
- Funct7 handling:
  - ALUOp=010 ignores Funct7 except for shifts (funct3 001/101).
  - Funct7=0100000 is legal only with funct3 000 (R-type) or 101.
- Illegal encodings: other Funct7 values on R-type/shift, funct3 010/011 under ALUOp 100, ALUOp 111. Each sets ex_illegal=1, Operation=ADD.
- EX register:
  - If stall=0, it captures the decode (ex_valid ← in_valid). Decode→Operation latency is 1 cycle.
  - If stall=1, it holds.
  - in_valid=0 inserts a bubble.
- FSM states IDLE and BUSY; LAT = DIV_LAT when Funct3[2]=1, else MUL_LAT.
  - IDLE, EX holds a valid M op: md_start=1.
    - LAT==1: md_done=1, stall=0, stay IDLE.
    - LAT>1: stall=1, counter←LAT-2, go BUSY.
  - BUSY, counter≠0: stall=1, counter decrements.
  - BUSY, counter==0: stall=0, md_done=1, go IDLE.
  - Net effect: an M op occupies EX for exactly LAT cycles.
- Back-to-back M ops: the second is captured on the first op's md_done cycle and starts in IDLE the next cycle, with no gap.
- Non-M ops never stall.
- flush has priority over stall. Next cycle: ex_valid=0, state=IDLE, counter=0. md_done is not asserted for the aborted op.
- reset mid-op behaves like flush and clears Operation to 0.
- in_valid high during stall is held upstream and not lost (in_ready=0).

Decomposition:
- Package alu_ctrl_pkg:
  - ALUOp class enum.
  - Operation code localparams (OP_ADD … OP_REMU).
  - Funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
- Sub-module alu_md_seq: IDLE/BUSY FSM plus counter. Inputs: start_valid, is_div, flush. Outputs: stall, md_start, md_busy, md_done.

Test Plan:
- Reset: reset high 2 cycles, then ALUOp=000 F7=0100000 F3=000 in_valid=1 → next cycle Operation=00110, ex_valid=1, stall=0.
- Legacy regression: sweep all ALUOp/F3 legal combos → Operation matches base table. Example: ALUOp=100 F3=111 → 01101; ALUOp=110 → 01110.
- MUL (MUL_LAT=3): F7=0000001 F3=000 → Operation=10000, md_start on cycle 1, stall high for 2 cycles, md_done on cycle 3, in_ready=0 for 2 cycles.
- DIVU followed by MUL: divu occupies EX 33 cycles; MUL captured on the md_done cycle then runs 3 cycles. Total 36 EX cycles, no bubble.
- Flush mid-DIV at BUSY cycle 10 → next cycle ex_valid=0, md_busy=0, stall=0; md_done never pulses.
- Illegal: F7=0000010 ALUOp=000 → ex_illegal=1, Operation=00010. With ENABLE_M=0, F7=0000001 → ex_illegal=1 and no stall.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the RV32IM ALU controller.
//   alu_class_e  : ALUOp class driven by the main decoder
//   OP_*         : 5-bit Operation codes seen by the EX-stage datapath
//   F7_*         : Funct7 encodings that select base, alternate and M ops
//   decode_t     : result bundle of the combinational decoder
//   alu_base_op  : shared R/I-type funct3 table (no alternate encodings)
//   md_op        : funct3 -> M-extension operation code
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_R      = 3'b000,
    ALU_MEM    = 3'b001,
    ALU_I      = 3'b010,
    ALU_JUMP   = 3'b011,
    ALU_BRANCH = 3'b100,
    ALU_AUIPC  = 3'b101,
    ALU_LUI    = 3'b110,
    ALU_RSVD   = 3'b111
  } alu_class_e;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_XOR    = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_BEQ    = 5'b01000;
  localparam logic [4:0] OP_BNE    = 5'b01001;
  localparam logic [4:0] OP_SLT    = 5'b01010;
  localparam logic [4:0] OP_BLT    = 5'b01010;
  localparam logic [4:0] OP_BGE    = 5'b01011;
  localparam logic [4:0] OP_SLTU   = 5'b01100;
  localparam logic [4:0] OP_BLTU   = 5'b01100;
  localparam logic [4:0] OP_BGEU   = 5'b01101;
  localparam logic [4:0] OP_LUI    = 5'b01110;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [4:0] op;
    logic       illegal;
    logic       is_m;
  } decode_t;

  // Funct3 table shared by R-type (Funct7=0) and I-type; shifts are
  // resolved by the caller because their Funct7 rules differ.
  function automatic logic [4:0] alu_base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  function automatic logic [4:0] md_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_MUL;
      3'b001:  return OP_MULH;
      3'b010:  return OP_MULHSU;
      3'b011:  return OP_MULHU;
      3'b100:  return OP_DIV;
      3'b101:  return OP_DIVU;
      3'b110:  return OP_REM;
      default: return OP_REMU;
    endcase
  endfunction

endpackage

// File: rtl/alu_md_seq.sv
// alu_md_seq: IDLE/BUSY latency sequencer for multi-cycle MUL/DIV ops.
//   clk, reset   : core clock, synchronous active-high reset
//   start_valid  : EX register holds a live M op
//   is_div       : that op is DIV/DIVU/REM/REMU (selects DIV_LAT)
//   flush        : abort the op in EX
//   stall        : hold ID and EX registers
//   md_start     : first EX cycle of an M op
//   md_busy      : sequencer is in BUSY
//   md_done      : final EX cycle of an M op
module alu_md_seq #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic start_valid,
  input  logic is_div,
  input  logic flush,
  output logic stall,
  output logic md_start,
  output logic md_busy,
  output logic md_done
);

  typedef enum logic {IDLE, BUSY} state_e;

  // The first EX cycle is spent in IDLE, so BUSY counts down LAT-2..0.
  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);
  localparam bit MUL_ONE = (MUL_LAT == 1);
  localparam bit DIV_ONE = (DIV_LAT == 1);

  state_e           state;
  logic [CNT_W-1:0] count;
  logic             single;

  assign single  = is_div ? DIV_ONE : MUL_ONE;
  assign md_busy = (state == BUSY);

  // Handshake outputs must act in the same cycle the op reaches EX, so they
  // are decoded from state; a flush suppresses all of them.
  always_comb begin
    stall    = 1'b0;
    md_start = 1'b0;
    md_done  = 1'b0;
    if (!flush) begin
      if (state == IDLE && start_valid) begin
        md_start = 1'b1;
        if (single) md_done = 1'b1;
        else        stall   = 1'b1;
      end else if (state == BUSY) begin
        if (count != '0) stall   = 1'b1;
        else             md_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid && !single) begin
            state <= BUSY;
            count <= is_div ? DIV_RELOAD : MUL_RELOAD;
          end
        end
        BUSY: begin
          if (count != '0) count <= count - CNT_W'(1);
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: RV32IM ALU controller with ID->EX register and M-op sequencing.
//   clk, reset        : core clock, synchronous active-high reset
//   in_valid          : ID-stage instruction valid
//   ALUOp/Funct7/Funct3 : decode inputs from the main decoder / instruction
//   flush             : kill EX contents (redirect)
//   in_ready          : ID may advance (= !stall)
//   ex_valid          : EX register holds a live op
//   Operation         : registered 5-bit ALU operation code
//   ex_illegal        : registered illegal-encoding flag
//   md_start/busy/done, stall : M-op sequencing handshake
module alu_ctrl_md
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33,
  parameter int CNT_W    = $clog2(DIV_LAT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [2:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  input  logic       flush,
  output logic       in_ready,
  output logic       ex_valid,
  output logic [4:0] Operation,
  output logic       ex_illegal,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done,
  output logic       stall
);

  decode_t dec;
  logic    ex_is_m;

  // Illegal encodings leave op at ADD so EX still sees a harmless operation.
  always_comb begin
    dec = '{op: OP_ADD, illegal: 1'b0, is_m: 1'b0};
    case (alu_class_e'(ALUOp))
      ALU_R: begin
        if (ENABLE_M && Funct7 == F7_MULDIV) begin
          dec.op   = md_op(Funct3);
          dec.is_m = 1'b1;
        end else if (Funct7 == F7_BASE) begin
          dec.op = alu_base_op(Funct3);
        end else if (Funct7 == F7_ALT && Funct3 == 3'b000) begin
          dec.op = OP_SUB;
        end else if (Funct7 == F7_ALT && Funct3 == 3'b101) begin
          dec.op = OP_SRA;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      ALU_I: begin
        if (Funct3 == 3'b001) begin
          if (Funct7 == F7_BASE) dec.op = OP_SLL;
          else                   dec.illegal = 1'b1;
        end else if (Funct3 == 3'b101) begin
          if (Funct7 == F7_BASE)     dec.op = OP_SRL;
          else if (Funct7 == F7_ALT) dec.op = OP_SRA;
          else                       dec.illegal = 1'b1;
        end else begin
          dec.op = alu_base_op(Funct3);
        end
      end
      ALU_BRANCH: begin
        case (Funct3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          3'b110:  dec.op = OP_BLTU;
          3'b111:  dec.op = OP_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      ALU_MEM, ALU_JUMP, ALU_AUIPC: dec.op = OP_ADD;
      ALU_LUI:  dec.op = OP_LUI;
      default:  dec.illegal = 1'b1;
    endcase
  end

  // EX register: flush beats stall; a bubble still captures the decode but
  // is marked not-valid and never starts the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      Operation  <= OP_AND;
      ex_illegal <= 1'b0;
      ex_is_m    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_is_m  <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= in_valid;
      Operation  <= dec.op;
      ex_illegal <= dec.illegal;
      ex_is_m    <= in_valid & dec.is_m;
    end
  end

  alu_md_seq #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT),
    .CNT_W  (CNT_W)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .start_valid(ex_valid & ex_is_m),
    .is_div     (Operation[2]),
    .flush      (flush),
    .stall      (stall),
    .md_start   (md_start),
    .md_busy    (md_busy),
    .md_done    (md_done)
  );

  assign in_ready = ~stall;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: directed self-checking bench for alu_ctrl_md.
// A second instance with ENABLE_M=0 shares all inputs.
module tb_alu_ctrl_md;

  logic       clk = 1'b0;
  logic       reset, in_valid, flush;
  logic [2:0] ALUOp, Funct3;
  logic [6:0] Funct7;

  logic       in_ready, ex_valid, ex_illegal, md_start, md_busy, md_done, stall;
  logic [4:0] Operation;
  logic       nm_in_ready, nm_ex_valid, nm_ex_illegal, nm_md_start, nm_md_busy, nm_md_done, nm_stall;
  logic [4:0] nm_Operation;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_ctrl_md dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .flush(flush), .in_ready(in_ready),
    .ex_valid(ex_valid), .Operation(Operation), .ex_illegal(ex_illegal),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done), .stall(stall)
  );

  alu_ctrl_md #(.ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .flush(flush), .in_ready(nm_in_ready),
    .ex_valid(nm_ex_valid), .Operation(nm_Operation), .ex_illegal(nm_ex_illegal),
    .md_start(nm_md_start), .md_busy(nm_md_busy), .md_done(nm_md_done), .stall(nm_stall)
  );

  typedef struct {
    logic [2:0] aluop;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] op;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic [6:0] f7,
                                input logic [2:0] f3);
    in_valid = v;
    ALUOp    = op;
    Funct7   = f7;
    Funct3   = f3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stall_cnt, live_cnt, div_done_at, mul_start_at, mul_done_at, div_start_cnt, done_cnt;

    // R-type
    vecs.push_back('{3'b000, 7'b0000000, 3'b000, 5'b00010, 1'b0});
    vecs.push_back('{3'b000, 7'b0100000, 3'b000, 5'b00110, 1'b0});
    vecs.push_back('{3'b000, 7'b0000000, 3'b001, 5'b00100, 1'b0});
    vecs.push_back('{3'b000, 7'b0000000, 3'b010, 5'b01010, 1'b0});
    vecs.push_back('{3'b000, 7'b0000000, 3'b011, 5'b01100, 1'b0});
    vecs.push_back('{3'b000, 7'b0000000, 3'b100, 5'b00011, 1'b0});
    vecs.push_back('{3'b000, 7'b0000000, 3'b101, 5'b00101, 1'b0});
    vecs.push_back('{3'b000, 7'b0100000, 3'b101, 5'b00111, 1'b0});
    vecs.push_back('{3'b000, 7'b0000000, 3'b110, 5'b00001, 1'b0});
    vecs.push_back('{3'b000, 7'b0000000, 3'b111, 5'b00000, 1'b0});
    vecs.push_back('{3'b000, 7'b0000010, 3'b000, 5'b00010, 1'b1});
    vecs.push_back('{3'b000, 7'b0100000, 3'b111, 5'b00010, 1'b1});
    // I-type
    vecs.push_back('{3'b010, 7'b0110011, 3'b000, 5'b00010, 1'b0});
    vecs.push_back('{3'b010, 7'b1111111, 3'b111, 5'b00000, 1'b0});
    vecs.push_back('{3'b010, 7'b0000000, 3'b001, 5'b00100, 1'b0});
    vecs.push_back('{3'b010, 7'b0000000, 3'b101, 5'b00101, 1'b0});
    vecs.push_back('{3'b010, 7'b0100000, 3'b101, 5'b00111, 1'b0});
    vecs.push_back('{3'b010, 7'b0100000, 3'b001, 5'b00010, 1'b1});
    vecs.push_back('{3'b010, 7'b0000001, 3'b101, 5'b00010, 1'b1});
    vecs.push_back('{3'b010, 7'b1010101, 3'b011, 5'b01100, 1'b0});
    // ADD classes, LUI, reserved
    vecs.push_back('{3'b001, 7'b1111111, 3'b010, 5'b00010, 1'b0});
    vecs.push_back('{3'b011, 7'b0000000, 3'b000, 5'b00010, 1'b0});
    vecs.push_back('{3'b101, 7'b0100000, 3'b111, 5'b00010, 1'b0});
    vecs.push_back('{3'b110, 7'b0000000, 3'b000, 5'b01110, 1'b0});
    vecs.push_back('{3'b111, 7'b0000000, 3'b000, 5'b00010, 1'b1});
    // Branches
    vecs.push_back('{3'b100, 7'b0000000, 3'b000, 5'b01000, 1'b0});
    vecs.push_back('{3'b100, 7'b0000000, 3'b001, 5'b01001, 1'b0});
    vecs.push_back('{3'b100, 7'b0000000, 3'b100, 5'b01010, 1'b0});
    vecs.push_back('{3'b100, 7'b0000000, 3'b101, 5'b01011, 1'b0});
    vecs.push_back('{3'b100, 7'b0000000, 3'b110, 5'b01100, 1'b0});
    vecs.push_back('{3'b100, 7'b0000000, 3'b111, 5'b01101, 1'b0});
    vecs.push_back('{3'b100, 7'b0000000, 3'b010, 5'b00010, 1'b1});
    vecs.push_back('{3'b100, 7'b0000000, 3'b011, 5'b00010, 1'b1});

    // Reset state
    reset = 1'b1;
    flush = 1'b0;
    apply_stimulus(1'b0, 3'b000, 7'b0000000, 3'b000);
    repeat (2) tick();
    check_output("reset ex_valid", 8'(ex_valid), 8'h0);
    check_output("reset Operation", 8'(Operation), 8'h00);
    check_output("reset ex_illegal", 8'(ex_illegal), 8'h0);
    check_output("reset stall", 8'(stall), 8'h0);
    check_output("reset in_ready", 8'(in_ready), 8'h1);
    check_output("reset md_flags", {5'b0, md_start, md_busy, md_done}, 8'h0);

    reset = 1'b0;
    apply_stimulus(1'b1, 3'b000, 7'b0100000, 3'b000);
    tick();
    check_output("first SUB op", 8'(Operation), 8'h06);
    check_output("first SUB valid", 8'(ex_valid), 8'h1);
    check_output("first SUB stall", 8'(stall), 8'h0);

    // Decode table
    foreach (vecs[i]) begin
      apply_stimulus(1'b1, vecs[i].aluop, vecs[i].f7, vecs[i].f3);
      tick();
      check_output($sformatf("vec%0d op", i), 8'(Operation), 8'(vecs[i].op));
      check_output($sformatf("vec%0d ill", i), 8'(ex_illegal), 8'(vecs[i].ill));
      check_output($sformatf("vec%0d valid", i), 8'(ex_valid), 8'h1);
      check_output($sformatf("vec%0d stall", i), 8'(stall), 8'h0);
    end

    // Bubble
    apply_stimulus(1'b0, 3'b000, 7'b0000000, 3'b000);
    tick();
    check_output("bubble valid", 8'(ex_valid), 8'h0);

    // MUL, 3 cycles; ENABLE_M=0 instance must flag illegal without stalling
    apply_stimulus(1'b1, 3'b000, 7'b0000001, 3'b000);
    tick();
    check_output("mul c1 op", 8'(Operation), 8'h10);
    check_output("mul c1 start", 8'(md_start), 8'h1);
    check_output("mul c1 stall", 8'(stall), 8'h1);
    check_output("mul c1 in_ready", 8'(in_ready), 8'h0);
    check_output("mul c1 busy/done", {6'b0, md_busy, md_done}, 8'h0);
    check_output("nom ill", 8'(nm_ex_illegal), 8'h1);
    check_output("nom op", 8'(nm_Operation), 8'h02);
    check_output("nom valid", 8'(nm_ex_valid), 8'h1);
    check_output("nom stall", 8'(nm_stall), 8'h0);
    check_output("nom in_ready", 8'(nm_in_ready), 8'h1);
    check_output("nom md_flags", {5'b0, nm_md_start, nm_md_busy, nm_md_done}, 8'h0);
    apply_stimulus(1'b1, 3'b000, 7'b0000000, 3'b000);
    tick();
    check_output("mul c2 start", 8'(md_start), 8'h0);
    check_output("mul c2 stall", 8'(stall), 8'h1);
    check_output("mul c2 in_ready", 8'(in_ready), 8'h0);
    check_output("mul c2 busy", 8'(md_busy), 8'h1);
    check_output("mul c2 op held", 8'(Operation), 8'h10);
    tick();
    check_output("mul c3 done", 8'(md_done), 8'h1);
    check_output("mul c3 stall", 8'(stall), 8'h0);
    check_output("mul c3 in_ready", 8'(in_ready), 8'h1);
    tick();
    check_output("after mul op", 8'(Operation), 8'h02);
    check_output("after mul valid", 8'(ex_valid), 8'h1);
    check_output("after mul busy", 8'(md_busy), 8'h0);
    check_output("after mul done", 8'(md_done), 8'h0);

    // DIVU then MUL back to back: 33 + 3 EX cycles, no gap
    apply_stimulus(1'b1, 3'b000, 7'b0000001, 3'b101);
    tick();
    stall_cnt = 0; live_cnt = 0; div_done_at = 0; mul_start_at = 0;
    mul_done_at = 0; div_start_cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      if (k > 1) tick();
      if (stall) stall_cnt++;
      if (ex_valid) live_cnt++;
      if (md_start && Operation == 5'b10101) div_start_cnt++;
      if (md_done && Operation == 5'b10101) div_done_at = k;
      if (md_start && Operation == 5'b10000) mul_start_at = k;
      if (md_done && Operation == 5'b10000) mul_done_at = k;
      if (k == 1) apply_stimulus(1'b1, 3'b000, 7'b0000001, 3'b000);
      if (k == 34) apply_stimulus(1'b0, 3'b000, 7'b0000000, 3'b000);
    end
    check_output("divu start pulses", 8'(div_start_cnt), 8'd1);
    check_output("divu done cycle", 8'(div_done_at), 8'd33);
    check_output("b2b mul start cycle", 8'(mul_start_at), 8'd34);
    check_output("b2b mul done cycle", 8'(mul_done_at), 8'd36);
    check_output("b2b stall cycles", 8'(stall_cnt), 8'd34);
    check_output("b2b live cycles", 8'(live_cnt), 8'd36);
    tick();
    check_output("b2b drained", 8'(ex_valid), 8'h0);

    // Flush at BUSY cycle 10 of a DIV
    apply_stimulus(1'b1, 3'b000, 7'b0000001, 3'b100);
    tick();
    apply_stimulus(1'b0, 3'b000, 7'b0000000, 3'b000);
    done_cnt = 0;
    repeat (10) begin
      tick();
      if (md_done) done_cnt++;
    end
    check_output("pre-flush busy", 8'(md_busy), 8'h1);
    check_output("pre-flush op", 8'(Operation), 8'h14);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_output("flush valid", 8'(ex_valid), 8'h0);
    check_output("flush busy", 8'(md_busy), 8'h0);
    check_output("flush stall", 8'(stall), 8'h0);
    check_output("flush in_ready", 8'(in_ready), 8'h1);
    repeat (40) begin
      tick();
      if (md_done) done_cnt++;
    end
    check_output("flush no done", 8'(done_cnt), 8'd0);

    // Reset mid MUL
    apply_stimulus(1'b1, 3'b000, 7'b0000001, 3'b011);
    tick();
    apply_stimulus(1'b0, 3'b000, 7'b0000000, 3'b000);
    tick();
    check_output("mulhu busy", 8'(md_busy), 8'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("midreset op", 8'(Operation), 8'h00);
    check_output("midreset valid", 8'(ex_valid), 8'h0);
    check_output("midreset busy", 8'(md_busy), 8'h0);
    check_output("midreset stall", 8'(stall), 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
